// File: rtl/pwm_bank.sv
// pwm_bank: NUM_CH-channel PWM with a shared prescaler and period counter, wrap-synchronised shadow registers; define PWM_BANK_CENTER_EN to add centre-aligned mode
module pwm_bank #(
   parameter int NUM_CH  = 4,
   parameter int WIDTH   = 16,
   parameter int PRESC_W = 8,
   parameter int ADR_W   = 4
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_cs,
   input  logic              i_wren,
   input  logic [ADR_W-1:0]  i_adr,
   input  logic [31:0]       i_di,
   output logic [31:0]       o_do,
   output logic [NUM_CH-1:0] o_out,
   output logic              o_wrap
);
   logic               r_en, r_inv, r_flag, r_upd, r_wrap;
   logic [PRESC_W-1:0] r_presc, r_pcnt;
   logic [WIDTH-1:0]   r_per_pend, r_per_act, r_cnt;
   logic [WIDTH-1:0]   r_duty_pend [NUM_CH];
   logic [WIDTH-1:0]   r_duty_act  [NUM_CH];
   logic [31:0]        r_do, w_rdata;
   logic [NUM_CH-1:0]  r_out;
   logic               w_wr, w_rd, w_wr_ctrl, w_tick, w_en_clr, w_wrap_ev, w_mode_chg, w_ctr;
   logic [WIDTH-1:0]   w_cnt_nxt;
   logic               w_unused;
   assign w_unused  = ^i_di;
   assign w_wr      = i_cs & i_wren;
   assign w_rd      = i_cs & ~i_wren;
   assign w_wr_ctrl = w_wr & (i_adr == ADR_W'(0));
   assign w_tick    = r_en & (r_pcnt == r_presc);
   assign w_en_clr  = w_wr_ctrl & r_en & ~i_di[0];
`ifdef PWM_BANK_CENTER_EN
   logic r_ctr, r_dir, w_down, w_cwrap;
   assign w_ctr      = r_ctr;
   assign w_mode_chg = w_wr_ctrl & (i_di[2] != r_ctr);
   assign w_down     = r_dir | (r_cnt == r_per_act);
   assign w_cwrap    = w_down & (r_cnt <= WIDTH'(1));
   assign w_wrap_ev  = w_tick & (r_ctr ? w_cwrap : (r_cnt == r_per_act));
   assign w_cnt_nxt  = r_ctr ? (w_cwrap ? '0 : w_down ? r_cnt - WIDTH'(1) : r_cnt + WIDTH'(1))
                             : (w_wrap_ev ? '0 : r_cnt + WIDTH'(1));
   // centre-mode select and count direction; direction falls back to up on wrap, disable or mode change
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_ctr <= 1'b0;
         r_dir <= 1'b0;
      end else begin
         if (w_wr_ctrl) r_ctr <= i_di[2];
         if (w_en_clr | w_mode_chg) r_dir <= 1'b0;
         else if (w_tick) r_dir <= r_ctr & w_down & ~w_cwrap;
      end
   end
`else
   assign w_ctr      = 1'b0;
   assign w_mode_chg = 1'b0;
   assign w_wrap_ev  = w_tick & (r_cnt == r_per_act);
   assign w_cnt_nxt  = w_wrap_ev ? '0 : r_cnt + WIDTH'(1);
`endif
   // register file: control, pending shadows, active copies loaded at wrap or disable, status flags
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_en        <= 1'b0;
         r_inv       <= 1'b0;
         r_presc     <= '0;
         r_per_pend  <= '0;
         r_per_act   <= '0;
         r_duty_pend <= '{default: '0};
         r_duty_act  <= '{default: '0};
         r_flag      <= 1'b0;
         r_upd       <= 1'b0;
      end else begin
         if (w_wr_ctrl) begin
            r_en    <= i_di[0];
            r_inv   <= i_di[1];
            r_presc <= i_di[8 +: PRESC_W];
         end
         if (w_wrap_ev | w_en_clr) begin
            r_per_act  <= r_per_pend;
            r_duty_act <= r_duty_pend;
            r_upd      <= 1'b0;
         end
         if (w_wr & (i_adr == ADR_W'(1))) begin
            r_per_pend <= i_di[WIDTH-1:0];
            r_upd      <= 1'b1;
         end
         for (int i = 0; i < NUM_CH; i++)
            if (w_wr & (i_adr == ADR_W'(4 + i))) begin
               r_duty_pend[i] <= i_di[WIDTH-1:0];
               r_upd          <= 1'b1;
            end
         if (w_wrap_ev) r_flag <= 1'b1;
         else if (w_wr & (i_adr == ADR_W'(2)) & i_di[0]) r_flag <= 1'b0;
      end
   end
   // prescaler and period counter; disable zeroes both, a mode change restarts the period
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_pcnt <= '0;
         r_cnt  <= '0;
      end else if (w_en_clr) begin
         r_pcnt <= '0;
         r_cnt  <= '0;
      end else if (r_en) begin
         r_pcnt <= w_tick ? '0 : r_pcnt + PRESC_W'(1);
         if (w_mode_chg) r_cnt <= '0;
         else if (w_tick) r_cnt <= w_cnt_nxt;
      end
   end
   // read mux for the register map; unmapped indices read 0
   always_comb begin
      w_rdata = '0;
      if (i_adr == ADR_W'(0)) begin
         w_rdata[0]            = r_en;
         w_rdata[1]            = r_inv;
         w_rdata[2]            = w_ctr;
         w_rdata[8 +: PRESC_W] = r_presc;
      end
      if (i_adr == ADR_W'(1)) w_rdata[WIDTH-1:0] = r_per_pend;
      if (i_adr == ADR_W'(2)) w_rdata[1:0] = {r_upd, r_flag};
      if (i_adr == ADR_W'(3)) w_rdata[WIDTH-1:0] = r_cnt;
      for (int i = 0; i < NUM_CH; i++)
         if (i_adr == ADR_W'(4 + i)) w_rdata[WIDTH-1:0] = r_duty_pend[i];
   end
   // registered outputs: read data, wrap pulse and PWM compare
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_do   <= '0;
         r_out  <= '0;
         r_wrap <= 1'b0;
      end else begin
         r_do   <= w_rd ? w_rdata : '0;
         r_wrap <= w_wrap_ev;
         for (int i = 0; i < NUM_CH; i++)
            r_out[i] <= r_en ? ((r_cnt < r_duty_act[i]) ^ r_inv) : r_inv;
      end
   end
   assign o_do   = r_do;
   assign o_out  = r_out;
   assign o_wrap = r_wrap;
endmodule

// File: doc/pwm_bank.md
Name: pwm_bank

Overview:
- Parametrised successor to the single-channel 8-bit MMIO PWM.
- Implements NUM_CH PWM channels of WIDTH-bit resolution, sharing one prescaler and one period counter.
- Duty and period writes are double-buffered and take effect only at period wrap, so outputs are glitch-free.
- Sits in the MMIO region on the shared OR read bus; outputs feed the heartbeat/LED logic or pins.

Parameters:
NUM_CH, 4, number of PWM channels (1..12)
WIDTH, 16, counter/period/duty width in bits (8..32)
PRESC_W, 8, prescaler register width in bits
ADR_W, 4, word-address width; decoded from adr[ADR_W+1:2]

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
cs  in  1  block select; one access per cycle while high
wren  in  1  write strobe; qualified by cs
adr  in  ADR_W  word index (bus adr[ADR_W+1:2])
di  in  32  write data
do  out  32  read data; zero when not selected
out  out  NUM_CH  PWM waveforms
wrap  out  1  one-cycle pulse at period wrap

Behaviour:
- Register map (word index):
  - 0 CTRL: [0] enable, [1] invert, [2] centre mode (see Optional Feature), [8+PRESC_W-1:8] presc.
  - 1 PERIOD: WIDTH bits.
  - 2 STATUS: [0] sticky wrap flag, write-1-to-clear; [1] update-pending (read-only).
  - 3 CNT: read-only current counter value.
  - 4..4+NUM_CH-1: DUTY[i], WIDTH bits.
  - Indices beyond the map read 0 and writes are ignored.
- Reads: do is registered and valid the cycle after cs (one-cycle latency, matching the bus ready). It is 0 in every cycle not preceded by cs&~wren. Unused upper bits read 0.
- Writes take effect on the cs&wren edge. PERIOD and DUTY writes go to the pending registers and set update-pending. Reads of PERIOD/DUTY return the pending value.
- Prescaler: pcnt counts 0..presc. tick = enable & (pcnt==presc). presc=0 gives a tick every cycle.
- Counter (edge mode): on tick, cnt increments; if cnt==period_act, cnt←0 and wrap event fires.
- On a wrap event:
  - period_act and duty_act[] load from pending; update-pending clears.
  - STATUS[0] sets; wrap pulses high for one cycle.
- Output: out[i] = enable ? ((cnt < duty_act[i]) ^ invert) : invert. Registered, so one cycle after cnt.
- Boundaries:
  - duty_act=0 → constant inactive.
  - duty_act>period_act → constant active.
  - period_act=0 → cnt stays 0 and wrap fires every tick.
  - cnt wraps at period_act only; it never overflows WIDTH.
- Enable clear: pcnt and cnt reset to 0 immediately, and pending values load into the active registers on the same edge.
- Simultaneous events:
  - Write in the wrap cycle: the new pending value is not applied this wrap (active loads the old pending), and update-pending stays set.
  - W1C of STATUS[0] in the wrap cycle: set wins.
- Reset (async, any time): all registers, pcnt, cnt, do, out and wrap go to 0; pending and active values go to 0. out=0 because invert=0.

Optional Feature:
- PWM_BANK_CENTER_EN defined:
  - CTRL[2] selects centre-aligned mode.
  - cnt counts up 0..period_act, then down to 0, with a direction register.
  - Wrap event (shadow load, flag, pulse) occurs only when cnt reaches 0 while counting down.
  - Output rule unchanged, giving symmetric pulses with full period 2*period_act ticks.
  - Clearing CTRL[2] mid-period resets cnt and direction to 0/up.
- Not defined:
  - CTRL[2] is a read-as-0 / write-ignored bit; edge mode only; no direction logic synthesised.

Test Plan:
1. Reset mid-run (enable=1, cnt≈7) → next cycle cnt=0, out=0, do=0, CTRL reads 0x0 after release.
2. presc=0, PERIOD=9, DUTY0=3, DUTY1=0, DUTY2=10, enable → after first wrap: out[0] high 3 of every 10 cycles, out[1] constant 0, out[2] constant 1; wrap pulses every 10 cycles.
3. Running at PERIOD=9, DUTY0=3; write DUTY0=7 at cnt=5 → current period keeps 3-cycle high; next period has 7-cycle high; STATUS[1]=1 until the wrap, then 0.
4. presc=3, PERIOD=4 → wrap every 20 clk cycles. STATUS[0] set; writing 0x1 clears it; writing 0x1 in the wrap cycle leaves it 1.
5. invert=1, enable=0 → all outs 1. Read of index 15 returns 0. Read of CNT returns 0. do=0 in the cycle after a cycle with cs=0.
6. PWM_BANK_CENTER_EN defined, CTRL[2]=1, presc=0, PERIOD=4, DUTY0=2 → cnt sequence 0,1,2,3,4,3,2,1,0; out[0] high while cnt<2; wrap only at down-count 0 (every 8 cycles).
